// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single shared memory port (IDLE -> BUSY -> TURN).
// Optional slave-response timeout is compiled in with `define MEMARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state, state_nxt;
  req_t [1:0]  req;
  logic [1:0]  valid;
  logic        last_gnt;   // index of the master granted most recently
  logic        win;
  logic        busy;
  logic        done;
  logic        to_hit;
  logic [31:0] rsp_data;

  assign valid  = {m1_valid, m0_valid};
  assign req[0] = {m0_addr, m0_wdata, m0_wstrb};
  assign req[1] = {m1_addr, m1_wdata, m1_wstrb};
  assign busy   = (state == BUSY);

  // Round robin: on contention the master not granted last wins.
  always_comb begin
    win = valid[1];
    if (valid == 2'b11) win = ~last_gnt;
  end

  // s_ready has priority over timeout since to_hit is qualified by !s_ready.
  assign done = busy & (s_ready | to_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|valid) state_nxt = BUSY;
      BUSY:    if (done)   state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant    <= 2'b00;
      last_gnt <= 1'b1;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
    end else if (state == IDLE && |valid) begin
      grant                       <= win ? 2'b10 : 2'b01;
      last_gnt                    <= win;
      {s_addr, s_wdata, s_wstrb}  <= req[win];
    end else if (done) begin
      grant <= 2'b00;
    end
  end

  assign s_valid  = busy;
  assign rsp_data = to_hit ? ERR_RDATA : s_rdata;
  assign m0_ready = done & grant[0];
  assign m1_ready = done & grant[1];
  assign m0_rdata = grant[0] ? rsp_data : '0;
  assign m1_rdata = grant[1] ? rsp_data : '0;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Fires in the BUSY cycle whose increment would reach TIMEOUT_CYCLES.
  assign to_hit = busy & ~s_ready & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!busy)          to_cnt <= '0;
      else if (!s_ready)  to_cnt <= to_cnt + 1'b1;
      if (to_hit)         timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
